// File: rtl/branch_pc_unit_pkg.sv
// Shared types for the branch/PC unit: condition codes, FSM states, flag-triple layout.
package branch_pkg;

    typedef enum logic [2:0] {
        EQ  = 3'd0,
        AB  = 3'd1,
        BL  = 3'd2,
        AE  = 3'd3,
        BE  = 3'd4,
        NE  = 3'd5,
        AL  = 3'd6,
        RSV = 3'd7
    } cond_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Flag triple is packed as {above, equal, below}.
    localparam int unsigned FLAG_BELOW = 0;
    localparam int unsigned FLAG_EQUAL = 1;
    localparam int unsigned FLAG_ABOVE = 2;

    function automatic logic is_one_hot(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

endpackage

// File: rtl/branch_pc_unit_cond_eval.sv
// Combinational branch condition evaluation against a comparator flag triple.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] flags,
    input  logic       flags_ok,
    input  logic [2:0] code,
    output logic       cond_true
);

    logic ab;
    logic eq;
    logic bl;

    assign ab = flags[FLAG_ABOVE];
    assign eq = flags[FLAG_EQUAL];
    assign bl = flags[FLAG_BELOW];

    always_comb begin
        cond_true = 1'b0;
        if (!flags_ok) begin
            // Without a valid comparison only the unconditional code may fire.
            cond_true = (code == AL);
        end else begin
            case (cond_e'(code))
                EQ:      cond_true = eq;
                AB:      cond_true = ab;
                BL:      cond_true = bl;
                AE:      cond_true = ab | eq;
                BE:      cond_true = bl | eq;
                NE:      cond_true = !eq;
                AL:      cond_true = 1'b1;
                default: cond_true = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Flag register, branch/jump FSM and program counter with registered fetch-flush.
// Optional branch outcome counters when BRANCH_STATS_EN is defined.
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int unsigned PC_W         = 10,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmp_valid,
    input  logic            above,
    input  logic            equal,
    input  logic            below,
    input  logic            step,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_offset,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            taken,
    output logic            flags_ok,
    output logic            flag_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     br_taken_cnt,
    output logic [15:0]     br_nottaken_cnt
`endif
);

    localparam logic [PC_W-1:0] RST_PC     = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);
    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic            taken_q, taken_d;
    logic [2:0]      flags_q;
    logic            flags_ok_q;
    logic            flag_err_q;

    logic [2:0]      flags_in;
    logic [2:0]      eval_flags;
    logic            eval_ok;
    logic            cond_true;

    assign flags_in = {above, equal, below};

    // Same-cycle compare result is forwarded ahead of the stored flags.
    assign eval_flags = cmp_valid ? flags_in : flags_q;
    assign eval_ok    = cmp_valid | flags_ok_q;

    branch_cond_eval u_cond_eval (
        .flags     (eval_flags),
        .flags_ok  (eval_ok),
        .code      (br_cond),
        .cond_true (cond_true)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q    <= '0;
            flags_ok_q <= 1'b0;
            flag_err_q <= 1'b0;
        end else if (cmp_valid) begin
            flags_q    <= flags_in;
            flags_ok_q <= 1'b1;
            if (!is_one_hot(flags_in)) begin
                flag_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RST_PC;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            taken_q <= taken_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        taken_d = 1'b0;
        case (state_q)
            RUN: begin
                if (jmp_valid) begin
                    pc_d    = jmp_target;
                    state_d = FLUSH;
                    cnt_d   = FLUSH_INIT;
                    flush_d = 1'b1;
                    taken_d = 1'b1;
                end else if (br_valid) begin
                    if (cond_true) begin
                        pc_d    = pc_q + br_offset;
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                        flush_d = 1'b1;
                        taken_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end else if (step) begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            FLUSH: begin
                // Counter holds remaining flush cycles after the current one.
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

`ifdef BRANCH_STATS_EN
    logic        br_accept;
    logic [15:0] taken_cnt_q;
    logic [15:0] nottaken_cnt_q;

    assign br_accept = (state_q == RUN) && br_valid && !jmp_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else if (br_accept) begin
            if (cond_true) begin
                if (taken_cnt_q != '1) begin
                    taken_cnt_q <= taken_cnt_q + 16'd1;
                end
            end else begin
                if (nottaken_cnt_q != '1) begin
                    nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
                end
            end
        end
    end

    assign br_taken_cnt    = taken_cnt_q;
    assign br_nottaken_cnt = nottaken_cnt_q;
`endif

    assign pc       = pc_q;
    assign flush    = flush_q;
    assign taken    = taken_q;
    assign flags_ok = flags_ok_q;
    assign flag_err = flag_err_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit (FLUSH_CYCLES=1 and 3 instances).
module tb_branch_pc_unit;
    import branch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmp_valid;
    logic       above;
    logic       equal;
    logic       below;
    logic       step;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [9:0] br_offset;
    logic       jmp_valid;
    logic [9:0] jmp_target;

    logic [9:0] pc;
    logic       flush;
    logic       taken;
    logic       flags_ok;
    logic       flag_err;
    logic [9:0] pc3;
    logic       flush3;
    logic       taken3;
    logic       flags_ok3;
    logic       flag_err3;
`ifdef BRANCH_STATS_EN
    logic [15:0] tcnt;
    logic [15:0] ncnt;
    logic [15:0] tcnt3;
    logic [15:0] ncnt3;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    branch_pc_unit #(.PC_W(10), .RESET_PC(0), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .above(above), .equal(equal),
        .below(below), .step(step), .br_valid(br_valid), .br_cond(br_cond),
        .br_offset(br_offset), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .pc(pc), .flush(flush), .taken(taken), .flags_ok(flags_ok), .flag_err(flag_err)
`ifdef BRANCH_STATS_EN
        , .br_taken_cnt(tcnt), .br_nottaken_cnt(ncnt)
`endif
    );

    branch_pc_unit #(.PC_W(10), .RESET_PC(0), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .above(above), .equal(equal),
        .below(below), .step(step), .br_valid(br_valid), .br_cond(br_cond),
        .br_offset(br_offset), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .pc(pc3), .flush(flush3), .taken(taken3), .flags_ok(flags_ok3), .flag_err(flag_err3)
`ifdef BRANCH_STATS_EN
        , .br_taken_cnt(tcnt3), .br_nottaken_cnt(ncnt3)
`endif
    );

    task automatic idle();
        cmp_valid = 0; {above, equal, below} = 3'b000; step = 0;
        br_valid = 0; br_cond = EQ; br_offset = '0; jmp_valid = 0; jmp_target = '0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (pc !== 10'd0) begin errs++; $display("FAIL reset_pc got %0d exp 0", pc); end
        vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL reset_flush got %b exp 0", flush); end
        vecs++; if (taken !== 1'b0) begin errs++; $display("FAIL reset_taken got %b exp 0", taken); end
        vecs++; if (flags_ok !== 1'b0) begin errs++; $display("FAIL reset_flags_ok got %b exp 0", flags_ok); end
        vecs++; if (flag_err !== 1'b0) begin errs++; $display("FAIL reset_flag_err got %b exp 0", flag_err); end
    endtask

    task automatic test_step();
        step = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vecs++; if (pc !== 10'(i)) begin errs++; $display("FAIL step_pc got %0d exp %0d", pc, i); end
            vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL step_flush got %b exp 0", flush); end
        end
        step = 0;
        vecs++; if (flags_ok !== 1'b0) begin errs++; $display("FAIL step_flags_ok got %b exp 0", flags_ok); end
    endtask

    task automatic test_branch_eq();
        cmp_valid = 1; {above, equal, below} = 3'b010;
        tick();
        idle();
        vecs++; if (flags_ok !== 1'b1) begin errs++; $display("FAIL eq_flags_ok got %b exp 1", flags_ok); end
        vecs++; if (pc !== 10'd3) begin errs++; $display("FAIL eq_pc_hold got %0d exp 3", pc); end
        br_valid = 1; br_cond = EQ; br_offset = 10'd5;
        tick();
        idle();
        vecs++; if (pc !== 10'd8) begin errs++; $display("FAIL eq_pc got %0d exp 8", pc); end
        vecs++; if (flush !== 1'b1) begin errs++; $display("FAIL eq_flush got %b exp 1", flush); end
        vecs++; if (taken !== 1'b1) begin errs++; $display("FAIL eq_taken got %b exp 1", taken); end
        step = 1;
        tick();
        vecs++; if (pc !== 10'd8) begin errs++; $display("FAIL eq_step_in_flush got %0d exp 8", pc); end
        vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL eq_flush_end got %b exp 0", flush); end
        vecs++; if (taken !== 1'b0) begin errs++; $display("FAIL eq_taken_pulse got %b exp 0", taken); end
        tick();
        step = 0;
        vecs++; if (pc !== 10'd9) begin errs++; $display("FAIL eq_resume got %0d exp 9", pc); end
    endtask

    task automatic test_forward();
        do_reset();
        step = 1;
        tick();
        tick();
        step = 0;
        vecs++; if (pc !== 10'd2) begin errs++; $display("FAIL fwd_setup got %0d exp 2", pc); end
        cmp_valid = 1; {above, equal, below} = 3'b100;
        br_valid = 1; br_cond = AB; br_offset = 10'h3FC;
        tick();
        idle();
        vecs++; if (pc !== 10'd1022) begin errs++; $display("FAIL fwd_wrap_pc got %0d exp 1022", pc); end
        vecs++; if (taken !== 1'b1) begin errs++; $display("FAIL fwd_taken got %b exp 1", taken); end
        vecs++; if (flags_ok !== 1'b1) begin errs++; $display("FAIL fwd_flags_ok got %b exp 1", flags_ok); end
        tick();
    endtask

    task automatic test_no_flags();
        do_reset();
        br_valid = 1; br_cond = BL; br_offset = 10'd5;
        tick();
        idle();
        vecs++; if (pc !== 10'd1) begin errs++; $display("FAIL noflag_pc got %0d exp 1", pc); end
        vecs++; if (taken !== 1'b0) begin errs++; $display("FAIL noflag_taken got %b exp 0", taken); end
        vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL noflag_flush got %b exp 0", flush); end
        br_valid = 1; br_cond = AL; br_offset = 10'd3;
        tick();
        idle();
        vecs++; if (pc !== 10'd4) begin errs++; $display("FAIL noflag_al_pc got %0d exp 4", pc); end
        vecs++; if (taken !== 1'b1) begin errs++; $display("FAIL noflag_al_taken got %b exp 1", taken); end
        tick();
        cmp_valid = 1; {above, equal, below} = 3'b110;
        tick();
        idle();
        vecs++; if (flag_err !== 1'b1) begin errs++; $display("FAIL err_set got %b exp 1", flag_err); end
        vecs++; if (flags_ok !== 1'b1) begin errs++; $display("FAIL err_flags_ok got %b exp 1", flags_ok); end
        cmp_valid = 1; {above, equal, below} = 3'b001;
        tick();
        idle();
        vecs++; if (flag_err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b exp 1", flag_err); end
        br_valid = 1; br_cond = BL; br_offset = 10'd2;
        tick();
        idle();
        vecs++; if (pc !== 10'd6) begin errs++; $display("FAIL stored_bl_pc got %0d exp 6", pc); end
        tick();
`ifdef BRANCH_STATS_EN
        vecs++; if (tcnt !== 16'd2) begin errs++; $display("FAIL stats_taken got %0d exp 2", tcnt); end
        vecs++; if (ncnt !== 16'd1) begin errs++; $display("FAIL stats_nottaken got %0d exp 1", ncnt); end
`endif
    endtask

    task automatic test_jump_wins();
        jmp_valid = 1; jmp_target = 10'h3FF;
        br_valid = 1; br_cond = AL; br_offset = 10'd1;
        tick();
        idle();
        vecs++; if (pc !== 10'h3FF) begin errs++; $display("FAIL jmp_pc got %0h exp 3ff", pc); end
        vecs++; if (flush !== 1'b1) begin errs++; $display("FAIL jmp_flush got %b exp 1", flush); end
        tick();
        step = 1;
        tick();
        step = 0;
        vecs++; if (pc !== 10'd0) begin errs++; $display("FAIL jmp_step_wrap got %0d exp 0", pc); end
`ifdef BRANCH_STATS_EN
        vecs++; if (tcnt !== 16'd2) begin errs++; $display("FAIL stats_jmp_uncounted got %0d exp 2", tcnt); end
`endif
    endtask

    task automatic test_flush3();
        logic [3:0] exp1;
        logic [3:0] exp3;
        exp1 = 4'b1000;
        exp3 = 4'b1110;
        do_reset();
        jmp_valid = 1; jmp_target = 10'h010;
        tick();
        idle();
        vecs++; if (taken3 !== 1'b1) begin errs++; $display("FAIL f3_taken got %b exp 1", taken3); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (flush3 !== exp3[3-i]) begin errs++; $display("FAIL f3_flush cyc %0d got %b exp %b", i, flush3, exp3[3-i]); end
            vecs++; if (flush !== exp1[3-i]) begin errs++; $display("FAIL f1_flush cyc %0d got %b exp %b", i, flush, exp1[3-i]); end
            if (i == 1) begin
                vecs++; if (taken3 !== 1'b0) begin errs++; $display("FAIL f3_taken_pulse got %b exp 0", taken3); end
            end
            tick();
        end
        vecs++; if (pc3 !== 10'h010) begin errs++; $display("FAIL f3_pc got %0h exp 10", pc3); end
        step = 1;
        tick();
        step = 0;
        vecs++; if (pc3 !== 10'h011) begin errs++; $display("FAIL f3_resume got %0h exp 11", pc3); end
    endtask

    task automatic test_reset_midflush();
        jmp_valid = 1; jmp_target = 10'h020;
        tick();
        idle();
        tick();
        vecs++; if (flush3 !== 1'b1) begin errs++; $display("FAIL mid_in_flush got %b exp 1", flush3); end
        rst_n = 0;
        tick();
        rst_n = 1;
        vecs++; if (pc3 !== 10'd0) begin errs++; $display("FAIL mid_pc got %0d exp 0", pc3); end
        vecs++; if (flush3 !== 1'b0) begin errs++; $display("FAIL mid_flush got %b exp 0", flush3); end
        step = 1;
        tick();
        step = 0;
        vecs++; if (pc3 !== 10'd1) begin errs++; $display("FAIL mid_run got %0d exp 1", pc3); end
`ifdef BRANCH_STATS_EN
        vecs++; if (tcnt !== 16'd0) begin errs++; $display("FAIL stats_clear got %0d exp 0", tcnt); end
`endif
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_step();
        test_branch_eq();
        test_forward();
        test_no_flags();
        test_jump_wins();
        test_flush3();
        test_reset_midflush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
